// File: rtl/ysyx_22050612_ifu_if.sv
// Fetch-side bus bundle: the imem request/response port plus the IFU->IDU
// instruction handshake.
interface ysyx_22050612_ifu_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );
endinterface

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: one un-pipelined 32-bit fetch per PC, held for IDU
// until handshake; redirects replace the PC and squash any fetch in flight.
module ysyx_22050612_ifu #(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       redirect_valid,
   input  logic [63:0]                redirect_pc,
   ysyx_22050612_ifu_if.master        bus,
   output logic [63:0]                fetch_cnt
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] inst_pc_q, inst_pc_d;
   logic [63:0] cnt_q, cnt_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic [63:0] redirect_pc_al;

   assign redirect_pc_al = redirect_pc & ~64'h3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_REQ;
         pc_q      <= PC_RESET;
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_pc_al;
            end else if (bus.imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response coinciding with a redirect is stale and simply dropped.
            if (redirect_valid) begin
               pc_d    = redirect_pc_al;
               state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
            end else if (bus.imem_resp_valid) begin
               inst_d    = bus.imem_resp_data;
               inst_pc_d = pc_q;
               valid_d   = 1'b1;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redirect_pc_al;
               state_d = S_REQ;
            end else if (bus.inst_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 64'd4;
               cnt_d   = cnt_q + 64'd1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               pc_d = redirect_pc_al;
            end
            if (bus.imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   assign bus.imem_req_valid = (state_q == S_REQ) && !redirect_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign fetch_cnt          = cnt_q;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Randomized bench for ysyx_22050612_ifu: transaction-level PC/fetch model
// feeding a scoreboard that a separate monitor drains on IDU handshakes.
module tb_ysyx_22050612_ifu;

   localparam logic [63:0] PC0  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] PCW  = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] fetch_cnt;
   logic [63:0] fetch_cnt_w;

   always #5 clk = ~clk;

   ysyx_22050612_ifu_if bus ();
   ysyx_22050612_ifu_if bus_w ();

   ysyx_22050612_ifu #(.PC_RESET(PC0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus),
      .fetch_cnt      (fetch_cnt)
   );

   ysyx_22050612_ifu #(.PC_RESET(PCW)) dut_w (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (1'b0),
      .redirect_pc    (64'h0),
      .bus            (bus_w),
      .fetch_cnt      (fetch_cnt_w)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [63:0] pc;
   } exp_t;

   exp_t        sbq[$];
   bit          run = 1'b0;
   logic [63:0] ref_pc;
   logic [63:0] exp_cnt;
   bit          outstanding, stale, held;
   int          handshakes = 0;

   // Monitor: the held instruction must match the oldest expected fetch.
   always @(negedge clk) begin
      if (run) begin
         chk("inst_valid", {63'b0, bus.inst_valid}, {63'b0, sbq.size() != 0});
         if (bus.inst_valid && sbq.size() != 0) begin
            chk("inst", {32'b0, bus.inst}, {32'b0, sbq[0].d});
            chk("inst_pc", bus.inst_pc, sbq[0].pc);
            if (bus.inst_ready && !redirect_valid) begin
               chk("fetch_cnt", fetch_cnt, exp_cnt);
               exp_cnt = exp_cnt + 64'd1;
               handshakes++;
               void'(sbq.pop_front());
            end
         end
      end
   end

   // Reference model: architectural fetch PC and fetch bookkeeping.
   always @(negedge clk) begin
      if (run) begin
         bit exp_rv, acc;
         #1;
         exp_rv = !redirect_valid && !outstanding && !held;
         chk("req_valid", {63'b0, bus.imem_req_valid}, {63'b0, exp_rv});
         acc = exp_rv && bus.imem_req_ready;
         if (acc) chk("req_addr", bus.imem_req_addr, ref_pc);
         if (held && bus.inst_ready && !redirect_valid) begin
            ref_pc = ref_pc + 64'd4;
            held   = 1'b0;
         end
         if (bus.imem_resp_valid) begin
            outstanding = 1'b0;
            if (!stale && !redirect_valid) begin
               sbq.push_back('{d: bus.imem_resp_data, pc: ref_pc});
               held = 1'b1;
            end
            stale = 1'b0;
         end
         if (acc) begin
            outstanding = 1'b1;
            stale       = 1'b0;
         end
         if (redirect_valid) begin
            ref_pc = redirect_pc & ~64'h3;
            if (outstanding) stale = 1'b1;
            if (held) begin
               void'(sbq.pop_front());
               held = 1'b0;
            end
         end
      end
   end

   // Memory: one response per accepted request, 1..(max_dly+1) cycles later.
   bit pend = 1'b0;
   int dly  = 0;

   task automatic step(input int max_dly);
      bit acc, rsp;
      @(negedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready;
      rsp = bus.imem_resp_valid;
      @(posedge clk);
      #1;
      if (rsp) bus.imem_resp_valid = 1'b0;
      if (acc) begin
         pend = 1'b1;
         dly  = int'($urandom_range(max_dly, 0));
      end
      if (pend) begin
         if (dly == 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = $urandom;
            pend = 1'b0;
         end else begin
            dly--;
         end
      end
   endtask

   initial begin
      redirect_valid      = 1'b0;
      redirect_pc         = '0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.inst_ready      = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", bus.imem_req_addr, PC0);
      chk("rst_inst_valid", {63'b0, bus.inst_valid}, 64'd0);
      chk("rst_inst", {32'b0, bus.inst}, 64'd0);
      chk("rst_inst_pc", bus.inst_pc, 64'd0);
      chk("rst_fetch_cnt", fetch_cnt, 64'd0);

      rst_n       = 1'b1;
      ref_pc      = PC0;
      exp_cnt     = '0;
      outstanding = 1'b0;
      stale       = 1'b0;
      held        = 1'b0;
      run         = 1'b1;

      // Free-running memory: three instructions in nine cycles.
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      repeat (9) step(0);
      chk("free_cnt", fetch_cnt, 64'd3);

      // IDU backpressure: the held instruction must stay put.
      bus.inst_ready = 1'b0;
      repeat (8) step(0);
      bus.inst_ready = 1'b1;
      repeat (6) step(0);

      for (int i = 0; i < 3000; i++) begin
         bus.imem_req_ready = ($urandom_range(9, 0) < 7);
         bus.inst_ready     = ($urandom_range(9, 0) < 6);
         redirect_valid     = ($urandom_range(99, 0) < 8);
         redirect_pc        = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
         step(3);
      end

      redirect_valid     = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      repeat (12) step(0);
      chk("progress", {63'b0, handshakes > 100}, 64'd1);

      // Asynchronous reset in the middle of a fetch.
      bus.inst_ready = 1'b0;
      repeat (4) step(0);
      run   = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("arst_addr", bus.imem_req_addr, PC0);
      chk("arst_inst_valid", {63'b0, bus.inst_valid}, 64'd0);
      chk("arst_fetch_cnt", fetch_cnt, 64'd0);
      chk("arst_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // PC wrap on a second instance reset near the top of the address space.
   initial begin
      logic [63:0] wa[2];
      int n = 0;
      bus_w.imem_req_ready  = 1'b1;
      bus_w.inst_ready      = 1'b1;
      bus_w.imem_resp_valid = 1'b0;
      bus_w.imem_resp_data  = 32'h0000_0013;
      wa[0] = '0;
      wa[1] = '1;
      @(posedge rst_n);
      for (int c = 0; c < 15; c++) begin
         bit acc;
         @(negedge clk);
         acc = bus_w.imem_req_valid && bus_w.imem_req_ready;
         if (acc && n < 2) begin
            wa[n] = bus_w.imem_req_addr;
            n++;
         end
         @(posedge clk);
         #1;
         bus_w.imem_resp_valid = acc;
      end
      chk("wrap_reqs", 64'(n), 64'd2);
      chk("wrap_first", wa[0], PCW);
      chk("wrap_second", wa[1], 64'd0);
      chk("wrap_cnt", fetch_cnt_w, 64'd5);
   end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the single-issue RV64 NPC core. Holds the architectural fetch PC, issues one 32-bit instruction read per PC over a valid/ready request and valid-only response memory port, and presents the fetched word with its PC to the decode stage (IDU) through a valid/ready handshake. A redirect input from execute/commit replaces the PC; any in-flight or held fetch is squashed.

## Interface
- PC_RESET, 64'h0000_0000_8000_0000, fetch PC loaded on reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  replace the fetch PC this cycle (branch, jump or trap).
- redirect_pc  input  64  new PC; bits [1:0] are ignored and stored as 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  64  fetch address; always equals pc.
- imem_resp_valid  input  1  response data valid. One response per accepted request, never in the same cycle as acceptance.
- imem_resp_data  input  32  fetched instruction word.
- inst_valid  output  1  inst/inst_pc valid to IDU.
- inst_ready  input  1  IDU consumes the instruction.
- inst  output  32  instruction word to IDU.
- inst_pc  output  64  PC of inst.
- fetch_cnt  output  64  count of instructions handed to IDU.

## Operation
- States: REQ, WAIT, HOLD, DROP. Registers: pc, inst, inst_pc, inst_valid, fetch_cnt, state.
- Reset (async, rst_n=0): state=REQ, pc=PC_RESET, inst=32'h0, inst_pc=0, inst_valid=0, fetch_cnt=0. Combinational outputs follow from these: imem_req_valid=1 once reset is released, and imem_req_addr=PC_RESET.
- imem_req_valid = (state==REQ) && !redirect_valid. This keeps a request with a stale address from being accepted in a redirect cycle.
- REQ:
  - redirect: pc<=redirect_pc, stay in REQ.
  - else if imem_req_ready: go to WAIT.
- WAIT:
  - redirect and resp_valid together: drop the data, pc<=redirect_pc, go to REQ.
  - redirect only: pc<=redirect_pc, go to DROP.
  - resp_valid only: inst<=imem_resp_data, inst_pc<=pc, inst_valid<=1, go to HOLD.
- HOLD: inst_valid=1; inst and inst_pc stay stable until the handshake.
  - redirect (has priority over inst_ready): inst_valid<=0, pc<=redirect_pc, go to REQ. The held instruction is not counted.
  - else if inst_ready: inst_valid<=0, pc<=pc+4, fetch_cnt<=fetch_cnt+1, go to REQ.
- DROP: waits for the stale response.
  - resp_valid: discard the data, go to REQ.
  - A further redirect updates pc. If it arrives together with resp_valid, go to REQ with the new pc.
- Arithmetic: pc+4 is 64-bit and wraps modulo 2^64. fetch_cnt wraps from all-ones to 0.
- The response data is never inspected; decode of illegal encodings is left to IDU.

## Timing
- Minimum fetch-to-decode latency:
  - cycle N: request accepted.
  - cycle N+1: response returns; the next state is HOLD.
  - cycle N+2: inst_valid=1. If inst_ready=1, the handshake completes.
  - cycle N+3: the next request is issued.
- Peak throughput is one instruction per 3 cycles. No fetch pipelining.
- Stalls:
  - imem_req_ready=0 holds the FSM in REQ with addr stable.
  - Response delay holds WAIT.
  - inst_ready=0 holds HOLD with inst and inst_pc stable.
- Redirect takes effect on the next edge. The first request to the new PC has imem_req_valid=1 in the cycle after the redirect, or after the stale response in DROP.
- Reset asserted mid-fetch aborts the fetch immediately. A response that arrives after reset is released is a protocol violation by memory and is not handled.

## Test plan
- Reset then free-running memory (req_ready=1, 1-cycle response, inst_ready=1): imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008, one request every 3 cycles. inst_pc matches the address; fetch_cnt=3 after the third handshake.
- Backpressure: inst_ready=0 for 5 cycles in HOLD with inst=0x00000013 → inst, inst_pc and inst_valid are stable and no request is issued. On inst_ready=1, the next address is inst_pc+4.
- Redirect in WAIT to 0x80001003, response 2 cycles later with 0xDEADBEEF → inst_valid stays 0. The next request address is 0x80001000.
- Redirect and inst_ready together in HOLD, redirect_pc=0x80000100 → the next request is 0x80000100 and fetch_cnt is unchanged.
- Redirect in REQ while req_ready=1 → imem_req_valid=0 that cycle, and the next cycle requests the redirect PC.
- Wrap: PC_RESET=64'hFFFF_FFFF_FFFF_FFFC, one instruction consumed → the next imem_req_addr is 0.
